// File: rtl/ram_fill_check.sv
// ram_fill_check: memory fill-and-verify engine for a single-port RAM.
//
// When started, it writes the pattern (SEED + a) mod 2^DATA_WIDTH to words
// 0..NUM_WORDS-1. It then reads every word back and compares the returned data
// against the same pattern. The result stays valid until the next accepted start.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   start          begin a run (accepted in IDLE or DONE only)
//   ram_wdata      write data to RAM
//   ram_addr       address to RAM
//   ram_we         write enable to RAM
//   ram_rdata      RAM read data, valid RD_LAT cycles after the address
//   busy           high while writing, reading or draining
//   done           one-cycle pulse when a run completes
//   pass           last completed run had no mismatches
//   err_count      mismatches in last run, saturating
//   first_err_addr address of the first mismatch in last run (0 if none)
module ram_fill_check #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_WORDS  = 6,
    parameter int SEED       = 1,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH:0]   err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(NUM_WORDS - 1);
    localparam logic [2:0]            LAST_DRAIN = 3'(RD_LAT - 1);

    if (NUM_WORDS < 1 || NUM_WORDS > (2 ** ADDR_WIDTH)) begin : g_bad_num_words
        $error("ram_fill_check: NUM_WORDS must be in 1..2**ADDR_WIDTH");
    end
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("ram_fill_check: RD_LAT must be in 1..4");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr, addr_nxt;
    logic [2:0]            drain_cnt, drain_nxt;
    logic                  accept;

    // Read-compare pipeline: stage i holds the read issued i+1 cycles ago.
    logic                  vld_p  [RD_LAT];
    logic [DATA_WIDTH-1:0] exp_p  [RD_LAT];
    logic [ADDR_WIDTH-1:0] addr_p [RD_LAT];

    logic                  mismatch;
    logic [CNT_W-1:0]      err_nxt;

    // Unsigned wrap-around pattern.
    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a);
        return DATA_WIDTH'(SEED) + DATA_WIDTH'(a);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Control: state and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            addr      <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            addr      <= addr_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        drain_nxt = drain_cnt;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_WRITE;
                    addr_nxt  = '0;
                    accept    = 1'b1;
                end
            end
            S_WRITE: begin
                // Terminal compare on LAST_ADDR, so a full address space ends at
                // all-ones without an extra wrapped cycle.
                if (addr == LAST_ADDR) begin
                    state_nxt = S_READ;
                    addr_nxt  = '0;
                end else begin
                    addr_nxt = addr + 1'b1;
                end
            end
            S_READ: begin
                if (addr == LAST_ADDR) begin
                    state_nxt = S_DRAIN;
                    addr_nxt  = '0;
                    drain_nxt = '0;
                end else begin
                    addr_nxt = addr + 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_cnt == LAST_DRAIN) begin
                    state_nxt = S_DONE;
                end else begin
                    drain_nxt = drain_cnt + 1'b1;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_nxt = S_WRITE;
                    addr_nxt  = '0;
                    accept    = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // RAM-side outputs decode straight from the state register, so the async
    // reset drops ram_we without waiting for a clock edge.
    always_comb begin
        ram_we    = (state == S_WRITE);
        ram_addr  = (state == S_WRITE || state == S_READ) ? addr : '0;
        ram_wdata = (state == S_WRITE) ? pattern(addr) : '0;
        busy      = (state == S_WRITE || state == S_READ || state == S_DRAIN);
        done      = (state == S_DONE);
    end

    // Stage p0..p(RD_LAT-1): valid bits (reset, so no stale compare after abort)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) vld_p[i] <= 1'b0;
        end else begin
            vld_p[0] <= (state == S_READ);
            for (int i = 1; i < RD_LAT; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    // Stage p0..p(RD_LAT-1): expected data and address (qualified by vld_p)
    always_ff @(posedge clk) begin
        exp_p[0]  <= pattern(addr);
        addr_p[0] <= addr;
        for (int i = 1; i < RD_LAT; i++) begin
            exp_p[i]  <= exp_p[i-1];
            addr_p[i] <= addr_p[i-1];
        end
    end

    // Compare at the pipeline output
    always_comb begin
        mismatch = vld_p[RD_LAT-1] && (ram_rdata != exp_p[RD_LAT-1]);
        err_nxt  = mismatch ? sat_inc(err_count) : err_count;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count      <= '0;
            first_err_addr <= '0;
            pass           <= 1'b0;
        end else if (accept) begin
            err_count      <= '0;
            first_err_addr <= '0;
            pass           <= 1'b0;
        end else begin
            if (mismatch) begin
                err_count <= err_nxt;
                if (err_count == '0) first_err_addr <= addr_p[RD_LAT-1];
            end
            // Final compare lands on the last drain edge; fold it into pass.
            if (state == S_DRAIN && drain_cnt == LAST_DRAIN) pass <= (err_nxt == '0);
        end
    end

endmodule

// File: tb/tb_ram_fill_check.sv
module tb_ram_fill_check;

    logic clk;
    logic rst_a, rst_b, start_a, start_b;

    // Instance A: defaults (6 words, SEED 1, RD_LAT 1)
    logic [3:0] wdata_a, rdata_a;
    logic [5:0] addr_a, first_a;
    logic       we_a, busy_a, done_a, pass_a;
    logic [6:0] err_a;

    // Instance B: full address space, SEED 15, RD_LAT 2
    logic [3:0] wdata_b, rdata_b;
    logic [5:0] addr_b, first_b;
    logic       we_b, busy_b, done_b, pass_b;
    logic [6:0] err_b;

    ram_fill_check #(.DATA_WIDTH(4), .ADDR_WIDTH(6), .NUM_WORDS(6), .SEED(1), .RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a),
        .ram_wdata(wdata_a), .ram_addr(addr_a), .ram_we(we_a), .ram_rdata(rdata_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a), .first_err_addr(first_a)
    );

    ram_fill_check #(.DATA_WIDTH(4), .ADDR_WIDTH(6), .NUM_WORDS(64), .SEED(15), .RD_LAT(2)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b),
        .ram_wdata(wdata_b), .ram_addr(addr_b), .ram_we(we_b), .ram_rdata(rdata_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b), .first_err_addr(first_b)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Behavioural RAMs; xor_* corrupts read data at chosen addresses.
    logic [3:0] mem_a [64];
    logic [3:0] mem_b [64];
    logic [3:0] xor_a [64];
    logic [3:0] xor_b [64];
    logic [3:0] rd_a, rd_b1, rd_b2;

    always @(posedge clk) begin
        if (we_a) mem_a[addr_a] <= wdata_a;
        rd_a <= mem_a[addr_a] ^ xor_a[addr_a];
        if (we_b) mem_b[addr_b] <= wdata_b;
        rd_b1 <= mem_b[addr_b] ^ xor_b[addr_b];
        rd_b2 <= rd_b1;
    end
    assign rdata_a = rd_a;
    assign rdata_b = rd_b2;

    // Current-instance view
    bit         sel;
    logic       c_we, c_busy, c_done, c_pass;
    logic [5:0] c_addr, c_first;
    logic [3:0] c_wdata;
    logic [6:0] c_err;
    always_comb begin
        c_we = sel ? we_b : we_a;
        c_busy = sel ? busy_b : busy_a;
        c_done = sel ? done_b : done_a;
        c_pass = sel ? pass_b : pass_a;
        c_addr = sel ? addr_b : addr_a;
        c_first = sel ? first_b : first_a;
        c_wdata = sel ? wdata_b : wdata_a;
        c_err = sel ? err_b : err_a;
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0] wlog [64];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) start_b = v; else start_a = v;
    endtask

    function automatic int n_words();
        return sel ? 64 : 6;
    endfunction
    function automatic int rd_lat();
        return sel ? 2 : 1;
    endfunction
    function automatic int seed();
        return sel ? 15 : 1;
    endfunction

    // Reference result: count corrupted words inside the tested range.
    task automatic model(output bit p, output int e, output int f);
        int cnt;
        logic [3:0] x;
        cnt = 0;
        f = 0;
        for (int a = 0; a < n_words(); a++) begin
            x = sel ? xor_b[a] : xor_a[a];
            if (x != 4'h0) begin
                if (cnt == 0) f = a;
                cnt++;
            end
        end
        e = (cnt > 127) ? 127 : cnt;
        p = (cnt == 0);
    endtask

    // Called at a negedge. One-cycle start pulse, then a cycle-by-cycle trace
    // check; optional extra start pulse at cycle pulse_k.
    task automatic run_check(input string tag, input int pulse_k,
                             input bit exp_pass, input int exp_err, input int exp_first);
        int  busy_cnt, done_k, n, l, s;
        bit  trace_ok;
        logic ew;
        logic [5:0] ea;
        logic [3:0] ed;
        n = n_words(); l = rd_lat(); s = seed();
        busy_cnt = 0; done_k = -1; trace_ok = 1;
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        for (int k = 0; k < 400; k++) begin
            if (k > 0) @(negedge clk);
            if (k == pulse_k) set_start(1'b1);
            else if (k == pulse_k + 1) set_start(1'b0);
            if (c_done) begin
                done_k = k;
                break;
            end
            if (c_busy) busy_cnt++;
            if (k < n) begin
                ew = 1'b1; ea = 6'(k); ed = 4'((s + k) % 16);
                wlog[k] = c_wdata;
            end else if (k < 2 * n) begin
                ew = 1'b0; ea = 6'(k - n); ed = 4'h0;
            end else begin
                ew = 1'b0; ea = 6'h0; ed = 4'h0;
            end
            if (c_we !== ew || c_addr !== ea || c_wdata !== ed || c_busy !== (k < 2 * n + l))
                trace_ok = 0;
        end
        check({tag, "_trace"}, int'(trace_ok), 1);
        check({tag, "_busy_cycles"}, busy_cnt, 2 * n + l);
        check({tag, "_done_cycle"}, done_k, 2 * n + l);
        check({tag, "_pass"}, int'(c_pass), int'(exp_pass));
        check({tag, "_err_count"}, int'(c_err), exp_err);
        check({tag, "_first_err"}, int'(c_first), exp_first);
        @(negedge clk);
        check({tag, "_done_width"}, int'(c_done), 0);
        check({tag, "_pass_hold"}, int'(c_pass), int'(exp_pass));
    endtask

    task automatic clear_faults();
        for (int a = 0; a < 64; a++) begin
            xor_a[a] = 4'h0;
            xor_b[a] = 4'h0;
        end
    endtask

    typedef struct {
        logic [5:0] bad;
        logic [3:0] flip;
        logic       exp_pass;
        int         exp_err;
        int         exp_first;
    } vec_t;

    initial begin
        vec_t tbl [5];
        bit   mp;
        int   me, mf, ndone, gap;
        int   dk [$];
        int   prev;
        bit   found;

        tbl[0] = '{6'b000000, 4'h0, 1'b1, 0, 0};
        tbl[1] = '{6'b000001, 4'h8, 1'b0, 1, 0};
        tbl[2] = '{6'b100000, 4'h1, 1'b0, 1, 5};
        tbl[3] = '{6'b010100, 4'hF, 1'b0, 2, 2};
        tbl[4] = '{6'b111111, 4'h3, 1'b0, 6, 0};

        for (int a = 0; a < 64; a++) begin
            mem_a[a] = 4'h0;
            mem_b[a] = 4'h0;
        end
        clear_faults();
        sel = 0;
        rst_a = 0; rst_b = 0; start_a = 0; start_b = 0;

        // Reset with no clock edge
        #5 rst_a = 1; rst_b = 1;
        #1;
        check("rst_we", int'(we_a), 0);
        check("rst_busy", int'(busy_a), 0);
        check("rst_done", int'(done_a), 0);
        check("rst_pass", int'(pass_a), 0);
        check("rst_err", int'(err_a), 0);
        check("rst_first", int'(first_a), 0);
        check("rst_addr_wdata", int'({addr_a, wdata_a}), 0);
        check("rst_b_we_busy", int'({we_b, busy_b}), 0);
        @(negedge clk);
        @(negedge clk);
        rst_a = 0; rst_b = 0;
        @(negedge clk);

        // Reset mid-WRITE drops ram_we before the next edge
        start_a = 1;
        @(negedge clk);
        start_a = 0;
        @(negedge clk);
        @(negedge clk);
        check("midwrite_we_before", int'(we_a), 1);
        rst_a = 1;
        #1;
        check("midwrite_we_async", int'(we_a), 0);
        check("midwrite_busy_async", int'(busy_a), 0);
        @(negedge clk);
        rst_a = 0;
        @(negedge clk);

        // Clean run
        run_check("clean", -1, 1'b1, 0, 0);

        // Table-driven fault patterns
        for (int t = 0; t < 5; t++) begin
            clear_faults();
            for (int a = 0; a < 6; a++) xor_a[a] = tbl[t].bad[a] ? tbl[t].flip : 4'h0;
            run_check($sformatf("tbl%0d", t), -1, tbl[t].exp_pass, tbl[t].exp_err, tbl[t].exp_first);
        end

        // Addr 3 reads 5 instead of 4, addr 5 reads 0 instead of 6
        clear_faults();
        xor_a[3] = 4'h4 ^ 4'h5;
        xor_a[5] = 4'h6 ^ 4'h0;
        run_check("fault", -1, 1'b0, 2, 3);

        // Start during READ is ignored: one done only
        clear_faults();
        run_check("ignore_start", 8, 1'b1, 0, 0);
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done_a) ndone++;
        end
        check("ignore_start_extra_done", ndone, 0);

        // Start held high: back-to-back runs every 14 cycles
        xor_a[3] = 4'h1;
        xor_a[5] = 4'h6;
        start_a = 1;
        prev = -10;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (k == prev + 1) begin
                check("b2b_err_cleared", int'(err_a), 0);
                check("b2b_write_start", int'({busy_a, we_a, addr_a}), int'({1'b1, 1'b1, 6'd0}));
            end
            if (done_a) begin
                dk.push_back(k);
                check("b2b_err_at_done", int'(err_a), 2);
                prev = k;
            end
        end
        start_a = 0;
        check("b2b_done_count", dk.size(), 4);
        if (dk.size() >= 3) begin
            check("b2b_first_done", dk[0], 13);
            check("b2b_period1", dk[1] - dk[0], 14);
            check("b2b_period2", dk[2] - dk[1], 14);
        end
        found = 0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk);
            if (done_a) found = 1;
        end
        check("b2b_drain_done", int'(found), 1);
        @(negedge clk);

        // Reset during READ at address 2
        start_a = 1;
        @(negedge clk);
        start_a = 0;
        found = 0;
        for (int k = 0; k < 30; k++) begin
            if (busy_a && !we_a && addr_a == 6'd2) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("rstread_reached", int'(found), 1);
        rst_a = 1;
        #1;
        check("rstread_outputs", int'({we_a, addr_a, wdata_a, busy_a, done_a}), 0);
        check("rstread_results", int'({pass_a, err_a, first_a}), 0);
        @(negedge clk);
        rst_a = 0;
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done_a) ndone++;
        end
        check("rstread_no_done", ndone, 0);
        check("rstread_results_hold", int'({pass_a, err_a, first_a}), 0);
        clear_faults();
        run_check("after_rst", -1, 1'b1, 0, 0);

        // Randomized faults against the reference model
        for (int r = 0; r < 12; r++) begin
            clear_faults();
            for (int a = 0; a < 6; a++)
                if ($urandom_range(2) == 0) xor_a[a] = 4'($urandom_range(15, 1));
            model(mp, me, mf);
            gap = $urandom_range(3);
            for (int g = 0; g < gap; g++) @(negedge clk);
            run_check($sformatf("rnd%0d", r), -1, mp, me, mf);
        end

        // Full address space, wrapping pattern, RD_LAT 2
        clear_faults();
        sel = 1;
        model(mp, me, mf);
        run_check("wrap", -1, mp, me, mf);
        check("wrap_w0", int'(wlog[0]), 15);
        check("wrap_w1", int'(wlog[1]), 0);
        check("wrap_w63", int'(wlog[63]), 14);
        xor_b[0] = 4'h2;
        xor_b[63] = 4'h1;
        xor_b[40] = 4'h8;
        run_check("wrap_fault", -1, 1'b0, 3, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
